// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end: opcode constants, instruction
// width and the fetch sequencer state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_RESOLVE = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, taken branch or jump, with jump
// taking priority. All arithmetic wraps modulo 2^32.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] pc_out,
    input  logic [25:0]        target,
    input  logic               jump,
    input  logic               branch,
    input  logic               zero_inv,
    input  logic               alu_zero,
    output logic [INSTR_W-1:0] next_pc
);

    logic [INSTR_W-1:0]        pc4;
    logic [INSTR_W-1:0]        jump_pc;
    logic [INSTR_W-1:0]        branch_pc;
    logic signed [INSTR_W-1:0] branch_off;
    logic                      taken;

    always_comb begin
        pc4        = pc_out + 32'd4;
        // Word offset from the 16-bit immediate, sign extended then scaled by 4.
        branch_off = {{14{target[15]}}, target[15:0], 2'b00};
        branch_pc  = pc4 + $unsigned(branch_off);
        jump_pc    = {pc4[31:28], target, 2'b00};
        taken      = branch & (alu_zero ^ zero_inv);

        if (jump) begin
            next_pc = jump_pc;
        end else if (taken) begin
            next_pc = branch_pc;
        end else begin
            next_pc = pc4;
        end
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch front end: owns the PC, fetches one word per instruction over req/ack,
// holds it for decode, then waits for execute to resolve the next PC.
module instr_fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] pc_out,
    input  logic               resolve_valid,
    input  logic               jump,
    input  logic               branch,
    input  logic               zero_inv,
    input  logic               alu_zero
);

    // Low bits forced clear so the fetch address is always word aligned.
    localparam logic [INSTR_W-1:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] pc_next;
    logic [INSTR_W-1:0] instr_next;
    logic [INSTR_W-1:0] pc_out_next;
    logic               req_next;
    logic               valid_next;
    logic [INSTR_W-1:0] resolved_pc;

    next_pc_calc u_next_pc (
        .pc_out   (pc_out),
        .target   (instr[25:0]),
        .jump     (jump),
        .branch   (branch),
        .zero_inv (zero_inv),
        .alu_zero (alu_zero),
        .next_pc  (resolved_pc)
    );

    assign imem_addr = pc;

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        instr_next  = instr;
        pc_out_next = pc_out;
        req_next    = imem_req;
        valid_next  = instr_valid;

        unique case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
                req_next   = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_next  = imem_rdata;
                    pc_out_next = pc;
                    req_next    = 1'b0;
                    valid_next  = 1'b1;
                    state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    valid_next = 1'b0;
                    state_next = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                // Refetch is requested in the same edge the PC advances.
                if (resolve_valid) begin
                    pc_next    = resolved_pc;
                    req_next   = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
                req_next   = 1'b0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= PC_INIT;
            instr       <= '0;
            pc_out      <= PC_INIT;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            pc_out      <= pc_out_next;
            imem_req    <= req_next;
            instr_valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Randomised bench for instr_fetch_sequencer; two instances (reset PC 0 and 0xFFFF_FFFC)
// run in lockstep against a transaction-level next-PC model.
module tb_instr_fetch_sequencer;

    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        resolve_valid;
    logic        jump;
    logic        branch;
    logic        zero_inv;
    logic        alu_zero;

    logic        imem_req    [2];
    logic [31:0] imem_addr   [2];
    logic [31:0] instr       [2];
    logic        instr_valid [2];
    logic [31:0] pc_out      [2];

    logic [31:0] mpc [2];
    logic [31:0] rst_pc [2];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_sequencer #(.RESET_PC(RPC0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req[0]), .imem_addr(imem_addr[0]),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr[0]), .instr_valid(instr_valid[0]), .instr_ready(instr_ready),
        .pc_out(pc_out[0]), .resolve_valid(resolve_valid),
        .jump(jump), .branch(branch), .zero_inv(zero_inv), .alu_zero(alu_zero)
    );

    instr_fetch_sequencer #(.RESET_PC(RPC1)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(imem_req[1]), .imem_addr(imem_addr[1]),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr[1]), .instr_valid(instr_valid[1]), .instr_ready(instr_ready),
        .pc_out(pc_out[1]), .resolve_valid(resolve_valid),
        .jump(jump), .branch(branch), .zero_inv(zero_inv), .alu_zero(alu_zero)
    );

    // Next PC from the architectural rules, written with plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input bit j, input bit b, input bit zi, input bit az);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        int                 off;
        seq = pc + 32'd4;
        imm = ins[15:0];
        off = imm;
        if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (b && (az != zi)) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Checks both instances; instruction/pc_out only compared when a word should be held.
    task automatic check_outputs(input string tag, input bit req_e, input bit vld_e,
                                 input bit hold, input logic [31:0] word);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.req%0d", tag, k), {31'd0, imem_req[k]}, {31'd0, req_e});
            chk($sformatf("%s.valid%0d", tag, k), {31'd0, instr_valid[k]}, {31'd0, vld_e});
            if (req_e) chk($sformatf("%s.addr%0d", tag, k), imem_addr[k], mpc[k]);
            if (hold) begin
                chk($sformatf("%s.instr%0d", tag, k), instr[k], word);
                chk($sformatf("%s.pc_out%0d", tag, k), pc_out[k], mpc[k]);
            end
        end
    endtask

    task automatic clear_inputs;
        imem_ack = 0; imem_rdata = $urandom; instr_ready = 0; resolve_valid = 0;
        jump = 0; branch = 0; zero_inv = 0; alu_zero = 0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst.req%0d", k), {31'd0, imem_req[k]}, 32'd0);
            chk($sformatf("rst.valid%0d", k), {31'd0, instr_valid[k]}, 32'd0);
            chk($sformatf("rst.instr%0d", k), instr[k], 32'd0);
            chk($sformatf("rst.pc_out%0d", k), pc_out[k], rst_pc[k]);
            mpc[k] = rst_pc[k];
        end
        reset = 1'b0;
        tick();
        check_outputs("post_rst", 1, 0, 0, 0);
    endtask

    // One full instruction: fetch with ack_d wait states, issue with rdy_d stall cycles,
    // resolve after res_d idle cycles. Ignored inputs are toggled when spur is set.
    task automatic run_instr(input logic [31:0] word, input int ack_d, input int rdy_d,
                             input int res_d, input bit j, input bit b, input bit zi,
                             input bit az, input bit spur);
        check_outputs("fetch", 1, 0, 0, 0);
        for (int i = 0; i < ack_d; i++) begin
            clear_inputs();
            instr_ready   = spur & $urandom_range(0, 1);
            resolve_valid = spur & $urandom_range(0, 1);
            jump = $urandom_range(0, 1); branch = $urandom_range(0, 1);
            tick();
            check_outputs("fetch_wait", 1, 0, 0, 0);
        end
        clear_inputs();
        imem_ack = 1; imem_rdata = word;
        tick();
        clear_inputs();
        check_outputs("issue", 0, 1, 1, word);
        for (int i = 0; i < rdy_d; i++) begin
            clear_inputs();
            imem_ack      = spur & $urandom_range(0, 1);
            resolve_valid = spur & $urandom_range(0, 1);
            jump = $urandom_range(0, 1); alu_zero = $urandom_range(0, 1);
            tick();
            check_outputs("issue_wait", 0, 1, 1, word);
        end
        clear_inputs();
        instr_ready = 1;
        imem_ack    = spur & $urandom_range(0, 1);
        tick();
        clear_inputs();
        check_outputs("resolve", 0, 0, 0, 0);
        for (int i = 0; i < res_d; i++) begin
            clear_inputs();
            imem_ack    = spur & $urandom_range(0, 1);
            instr_ready = spur & $urandom_range(0, 1);
            jump = $urandom_range(0, 1); branch = $urandom_range(0, 1);
            tick();
            check_outputs("resolve_wait", 0, 0, 0, 0);
        end
        clear_inputs();
        resolve_valid = 1; jump = j; branch = b; zero_inv = zi; alu_zero = az;
        instr_ready   = spur & $urandom_range(0, 1);
        tick();
        clear_inputs();
        for (int k = 0; k < 2; k++) mpc[k] = model_next(mpc[k], word, j, b, zi, az);
        check_outputs("refetch", 1, 0, 0, 0);
    endtask

    task automatic reset_mid(input bit in_issue);
        check_outputs("mid_fetch", 1, 0, 0, 0);
        clear_inputs();
        if (in_issue) begin
            imem_ack = 1;
            tick();
            clear_inputs();
            check_outputs("mid_issue", 0, 1, 0, 0);
        end else begin
            tick();
            tick();
        end
        do_reset();
    endtask

    initial begin
        bit j, b;
        logic [31:0] w;
        rst_pc[0] = RPC0;
        rst_pc[1] = RPC1;
        clear_inputs();
        reset = 1'b1;

        do_reset();
        chk("first_addr", imem_addr[0], 32'h0000_0000);
        chk("first_addr_w", imem_addr[1], 32'hFFFF_FFFC);

        run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("second_addr", imem_addr[0], 32'h0000_0004);
        chk("wrap_addr", imem_addr[1], 32'h0000_0000);

        for (int i = 0; i < 3; i++) run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("seq_addr", imem_addr[0], 32'h0000_0010);

        run_instr(32'h0800_0010, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("jump_addr", imem_addr[0], 32'h0000_0040);
        run_instr(32'h0800_0040, 1, 1, 1, 1, 0, 0, 0, 0);
        chk("jump2_addr", imem_addr[0], 32'h0000_0100);

        run_instr(32'h1000_FFFE, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("br_taken", imem_addr[0], 32'h0000_00FC);
        run_instr(32'h0000_0020, 5, 3, 2, 0, 0, 0, 0, 1);
        chk("stall_seq", imem_addr[0], 32'h0000_0100);
        run_instr(32'h1000_FFFE, 0, 0, 0, 0, 1, 1, 1, 1);
        chk("br_inv", imem_addr[0], 32'h0000_0104);
        run_instr(32'h0800_0010, 0, 0, 0, 1, 1, 0, 1, 0);
        chk("jump_prio", imem_addr[0], 32'h0000_0040);

        reset_mid(1'b0);
        reset_mid(1'b1);
        chk("refetch_rst", imem_addr[0], 32'h0000_0000);

        for (int n = 0; n < 200; n++) begin
            j = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 2) == 0);
            w = $urandom;
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                      j, b, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
